// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC modular-subtract arbiter: FSM encoding and
// P-256 field constants.
package ecc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [255:0] P256_P     = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [255:0] P256_NEG_P = 256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000001;

endpackage

// File: rtl/full_sub.sv
// Plain WIDTH-bit subtractor with borrow out; the single shared datapath.
module full_sub #(
  parameter int W = 256
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after the
// pointer, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  logic [IDW:0]   slot;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    slot    = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, ptr_i} + (IDW+1)'(k);
      if (slot >= (IDW+1)'(NREQ)) slot = slot - (IDW+1)'(NREQ);
      cand = slot[IDW-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/ecc_modsub_arbiter.sv
// Round-robin shared (a - b) mod P / (0 - b) mod P unit: one subtract step,
// plus a +P correction step when the subtract borrows.
module ecc_modsub_arbiter
  import ecc_pkg::*;
#(
  parameter int              WIDTH = 256,
  parameter int              NREQ  = 4,
  parameter int              IDW   = 2,
  parameter logic [WIDTH-1:0] NEG_P = P256_NEG_P
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       neg,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      dout
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               borrow_q, borrow_d;

  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     win_idx;
  logic               win_vld;
  logic [WIDTH-1:0]   sub_a, sub_b, sub_diff;
  logic               sub_borrow;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  // FIX reuses the subtractor: dout - (2^WIDTH - P) == dout + P mod 2^WIDTH.
  assign sub_a = (state_q == FIX) ? dout_q : opa_q;
  assign sub_b = (state_q == FIX) ? NEG_P  : opb_q;

  full_sub #(.W(WIDTH)) u_sub (
    .a_i      (sub_a),
    .b_i      (sub_b),
    .diff_o   (sub_diff),
    .borrow_o (sub_borrow)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    done_id_d = done_id_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    dout_d    = dout_q;
    borrow_d  = borrow_q;
    ack       = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld && !rst) begin
          ack     = grant;
          opa_d   = neg[win_idx] ? '0 : a_in[int'(win_idx)*WIDTH +: WIDTH];
          opb_d   = b_in[int'(win_idx)*WIDTH +: WIDTH];
          id_d    = win_idx;
          ptr_d   = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        dout_d   = sub_diff;
        borrow_d = sub_borrow;
        if (sub_borrow) begin
          state_d = FIX;
        end else begin
          state_d   = DONE;
          done_id_d = id_q;
        end
      end
      FIX: begin
        if (borrow_q) dout_d = sub_diff;
        state_d   = DONE;
        done_id_d = id_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      done_id_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      dout_q    <= '0;
      borrow_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      done_id_q <= done_id_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      dout_q    <= dout_d;
      borrow_q  <= borrow_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_ecc_modsub_arbiter.sv
// Scoreboard bench for ecc_modsub_arbiter: expected results queued at ack,
// matched against done results.
module tb_ecc_modsub_arbiter;

  localparam int W  = 256;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam logic [255:0] PMOD = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, neg;
  logic [N*W-1:0]  a_in, b_in;
  logic [N-1:0]    ack;
  logic            busy, done;
  logic [IW-1:0]   done_id;
  logic [W-1:0]    dout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  val;
    int            cyc;
  } ev_t;

  ev_t          exp_q[$];
  ev_t          obs_q[$];
  logic [N-1:0] ack_log[$];

  ecc_modsub_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .neg     (neg),
    .a_in    (a_in),
    .b_in    (b_in),
    .ack     (ack),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .dout    (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, PMOD} - {1'b0, b};
    return t[W-1:0];
  endfunction

  always @(negedge clk) begin
    if (ack != '0) begin
      ev_t e;
      int  w;
      ack_log.push_back(ack);
      w = 0;
      for (int k = N-1; k >= 0; k--) if (ack[k]) w = k;
      e.id  = IW'(w);
      e.val = ref_sub(neg[w] ? '0 : a_in[w*W +: W], b_in[w*W +: W]);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (done) begin
      ev_t o;
      o.id  = done_id;
      o.val = dout;
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic logic [W-1:0] rand_lt_p();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = PMOD - 1;
      2: v = W'($urandom_range(0, 15));
      default: begin
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      end
    endcase
    if (v >= PMOD) v = v - PMOD;
    return v;
  endfunction

  task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic n, output ev_t e, output ev_t o, output bit ok);
    @(posedge clk);
    #1;
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    neg[i] = n;
    req[i] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack[i]) break;
    end
    @(posedge clk);
    #1;
    req[i] = 1'b0;
    for (int k = 0; k < 10 && obs_q.size() == 0; k++) @(negedge clk);
    ok = (obs_q.size() != 0) && (exp_q.size() != 0);
    if (ok) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
    end else begin
      o = '{default: '0};
      e = '{default: '0};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; neg = '0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    vectors++; if (ack !== '0)     begin miscompares++; $display("FAIL reset_ack got %h want 0", ack); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (done_id !== '0) begin miscompares++; $display("FAIL reset_done_id got %0d want 0", done_id); end
    vectors++; if (dout !== '0)    begin miscompares++; $display("FAIL reset_dout got %h want 0", dout); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simple();
    ev_t e, o; bit ok;
    run_op(0, 256'd10, 256'd3, 1'b0, e, o, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL simple_timeout got no result want one"); end
    vectors++; if (o.val !== 256'd7) begin miscompares++; $display("FAIL simple_dout got %h want 7", o.val); end
    vectors++; if (o.id !== 2'd0) begin miscompares++; $display("FAIL simple_id got %0d want 0", o.id); end
    vectors++; if (o.cyc - e.cyc !== 2) begin miscompares++; $display("FAIL simple_latency got %0d want 2", o.cyc - e.cyc); end
  endtask

  task automatic test_borrow();
    ev_t e, o; bit ok;
    logic [W-1:0] want;
    want = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFF8;
    run_op(1, 256'd3, 256'd10, 1'b0, e, o, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL borrow_timeout got no result want one"); end
    vectors++; if (o.val !== want) begin miscompares++; $display("FAIL borrow_dout got %h want %h", o.val, want); end
    vectors++; if (o.id !== 2'd1) begin miscompares++; $display("FAIL borrow_id got %0d want 1", o.id); end
    vectors++; if (o.cyc - e.cyc !== 3) begin miscompares++; $display("FAIL borrow_latency got %0d want 3", o.cyc - e.cyc); end
  endtask

  task automatic test_neg();
    ev_t e, o; bit ok;
    run_op(2, 256'hDEADBEEF, 256'd1, 1'b1, e, o, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL neg1_timeout got no result want one"); end
    vectors++; if (o.val !== PMOD - 1) begin miscompares++; $display("FAIL neg1_dout got %h want %h", o.val, PMOD - 1); end
    vectors++; if (o.id !== 2'd2) begin miscompares++; $display("FAIL neg1_id got %0d want 2", o.id); end
    vectors++; if (o.cyc - e.cyc !== 3) begin miscompares++; $display("FAIL neg1_latency got %0d want 3", o.cyc - e.cyc); end
    run_op(2, 256'hCAFE, 256'd0, 1'b1, e, o, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL neg0_timeout got no result want one"); end
    vectors++; if (o.val !== '0) begin miscompares++; $display("FAIL neg0_dout got %h want 0", o.val); end
    vectors++; if (o.cyc - e.cyc !== 2) begin miscompares++; $display("FAIL neg0_latency got %0d want 2", o.cyc - e.cyc); end
    neg = '0;
  endtask

  task automatic test_all_req();
    logic [N-1:0] want_ack;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = W'(i + 5);
      b_in[i*W +: W] = W'(i);
    end
    neg = '0;
    req = '1;
    @(negedge clk);
    exp_q.delete(); obs_q.delete(); ack_log.delete();
    rst = 1'b0;
    for (int k = 0; k < 60 && ack_log.size() < 5; k++) @(negedge clk);
    @(posedge clk);
    #1;
    req = '0;
    for (int k = 0; k < 20 && obs_q.size() < 5; k++) @(negedge clk);
    vectors++; if (ack_log.size() != 5) begin miscompares++; $display("FAIL allreq_ack_count got %0d want 5", ack_log.size()); end
    vectors++; if (obs_q.size() != 5) begin miscompares++; $display("FAIL allreq_done_count got %0d want 5", obs_q.size()); end
    for (int k = 0; k < 5 && k < ack_log.size() && k < obs_q.size(); k++) begin
      want_ack = N'(1) << (k % N);
      vectors++; if (ack_log[k] !== want_ack) begin miscompares++; $display("FAIL allreq_ack[%0d] got %b want %b", k, ack_log[k], want_ack); end
      vectors++; if (obs_q[k].id !== IW'(k % N)) begin miscompares++; $display("FAIL allreq_id[%0d] got %0d want %0d", k, obs_q[k].id, k % N); end
      vectors++; if (obs_q[k].val !== 256'd5) begin miscompares++; $display("FAIL allreq_dout[%0d] got %h want 5", k, obs_q[k].val); end
    end
    exp_q.delete(); obs_q.delete(); ack_log.delete();
  endtask

  task automatic test_reset_mid();
    ev_t e, o; bit ok;
    @(posedge clk);
    #1;
    a_in[0 +: W] = 256'd3;
    b_in[0 +: W] = 256'd10;
    req[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack[0]) break;
    end
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(posedge clk);
    #2;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_prebusy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    vectors++; if (ack !== '0)     begin miscompares++; $display("FAIL midrst_ack got %h want 0", ack); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL midrst_done got %b want 0", done); end
    vectors++; if (done_id !== '0) begin miscompares++; $display("FAIL midrst_done_id got %0d want 0", done_id); end
    vectors++; if (dout !== '0)    begin miscompares++; $display("FAIL midrst_dout got %h want 0", dout); end
    a_in[3*W +: W] = 256'd20;
    b_in[3*W +: W] = 256'd5;
    neg[3] = 1'b0;
    req[3] = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL midrst_no_done got %0d results want 0", obs_q.size()); end
    exp_q.delete(); ack_log.delete();
    rst = 1'b0;
    for (int k = 0; k < 20 && ack_log.size() == 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    req[3] = 1'b0;
    for (int k = 0; k < 10 && obs_q.size() == 0; k++) @(negedge clk);
    ok = (obs_q.size() != 0) && (exp_q.size() != 0);
    vectors++; if (ack_log.size() == 0 || ack_log[0] !== 4'b1000) begin miscompares++; $display("FAIL midrst_grant got %0d acks want ack=1000", ack_log.size()); end
    vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_timeout got no result want one"); end
    if (ok) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++; if (o.id !== 2'd3) begin miscompares++; $display("FAIL midrst_id got %0d want 3", o.id); end
      vectors++; if (o.val !== 256'd15) begin miscompares++; $display("FAIL midrst_dout got %h want 15", o.val); end
    end
    exp_q.delete(); obs_q.delete(); ack_log.delete();
  endtask

  task automatic test_random();
    ev_t e, o; bit ok;
    int i;
    logic n;
    logic [W-1:0] a, b;
    for (int t = 0; t < 10000; t++) begin
      i = $urandom_range(0, N-1);
      n = 1'($urandom_range(0, 1));
      a = rand_lt_p();
      b = ($urandom_range(0, 7) == 0) ? a : rand_lt_p();
      run_op(i, a, b, n, e, o, ok);
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL rand_timeout[%0d] got no result want one", t);
      end else if (o.val !== e.val || o.id !== IW'(i)) begin
        miscompares++;
        $display("FAIL rand[%0d] got id=%0d dout=%h want id=%0d dout=%h", t, o.id, o.val, i, e.val);
      end
      neg[i] = 1'b0;
    end
    exp_q.delete(); obs_q.delete(); ack_log.delete();
  endtask

  initial begin
    test_reset();
    test_simple();
    test_borrow();
    test_neg();
    test_all_req();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
